// File: rtl/rgb_scandoubler.sv
// rtl/rgb_scandoubler.sv - 15 kHz to 31 kHz line doubler with ping-pong line buffer and scanline dimming
module rgb_scandoubler #(
  parameter int LINE_MAX = 512,
  parameter int ADDR_W   = 9,
  parameter int LEN_W    = 10
) (
  input  logic        clkvideo,
  input  logic        reset_n,
  input  logic        ce_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic [11:0] rgb_in,
  input  logic        scanlines_en,
  output logic [11:0] rgb_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        overflow
);

  typedef enum logic [1:0] {S_IDLE, S_SYNC, S_ACTIVE} state_t;

  localparam logic [LEN_W-1:0] LEN_MAX_SLOT = LEN_W'(LINE_MAX);
  localparam logic [LEN_W-1:0] LEN_ONE      = LEN_W'(1);
  localparam logic [LEN_W-1:0] LEN_TWO      = LEN_W'(2);

  // Two banks of LINE_MAX pixel slots; bank bit is the address MSB.
  logic [11:0] mem [0:2*LINE_MAX-1];

  // Input side state
  logic             hsync_in_q;
  logic [LEN_W-1:0] wr_cnt;
  logic [LEN_W-1:0] hs_cnt;
  logic [LEN_W-1:0] line_len;
  logic [LEN_W-1:0] hs_width;
  logic             wr_bank;
  logic             line_valid;
  logic             seen_rise;

  // Output side state
  state_t           state, state_n;
  logic [LEN_W-1:0] out_h, out_h_n;
  logic             pass, pass_n;

  // Read pipeline
  logic [ADDR_W:0]  rd_addr;
  logic             show, sync;
  logic [11:0]      rd_data;
  logic             show_d1, sync_d1, pass_d1, vs_d1;

  // Write side combinational helpers
  logic             hs_rise;
  logic             line_ok;
  logic             wr_en;
  logic             wr_bank_sel;
  logic [ADDR_W-1:0] wr_slot;
  logic [LEN_W-1:0] wr_cnt_inc;
  logic [LEN_W-1:0] hs_cnt_inc;
  logic             lv_n;
  logic [LEN_W-1:0] hw_n;

  function automatic logic [11:0] dim(input logic [11:0] c);
    return {1'b0, c[11:9], 1'b0, c[7:5], 1'b0, c[3:1]};
  endfunction

  // The rising-edge pixel is slot 0 of the new bank, so a line's length
  // and its hsync width both include the ce_in that starts the pulse.
  assign hs_rise     = ce_in & hsync_in & ~hsync_in_q;
  assign line_ok     = seen_rise & (wr_cnt >= LEN_TWO);
  assign wr_bank_sel = hs_rise ? ~wr_bank : wr_bank;
  assign wr_slot     = hs_rise ? ADDR_W'(0) : wr_cnt[ADDR_W-1:0];
  assign wr_en       = ce_in & (hs_rise | (wr_cnt < LEN_MAX_SLOT));
  assign wr_cnt_inc  = (wr_cnt == '1) ? wr_cnt : wr_cnt + LEN_ONE;
  assign hs_cnt_inc  = (hs_cnt == '1) ? hs_cnt : hs_cnt + LEN_ONE;

  // Capture counters, line geometry and bank flip on the source strobe
  always_ff @(posedge clkvideo or negedge reset_n) begin
    if (!reset_n) begin
      hsync_in_q <= 1'b0;
      wr_cnt     <= '0;
      hs_cnt     <= '0;
      line_len   <= '0;
      hs_width   <= '0;
      wr_bank    <= 1'b0;
      line_valid <= 1'b0;
      seen_rise  <= 1'b0;
      overflow   <= 1'b0;
    end else if (ce_in) begin
      hsync_in_q <= hsync_in;
      if (hs_rise) begin
        line_len   <= wr_cnt;
        hs_width   <= hs_cnt;
        wr_cnt     <= LEN_ONE;
        hs_cnt     <= LEN_ONE;
        wr_bank    <= ~wr_bank;
        line_valid <= line_ok;
        seen_rise  <= 1'b1;
      end else begin
        wr_cnt <= wr_cnt_inc;
        if (hsync_in) hs_cnt <= hs_cnt_inc;
        if (wr_cnt >= LEN_MAX_SLOT) overflow <= 1'b1;
      end
    end
  end

  // Line RAM: one write port from the capture side, one registered read port
  always_ff @(posedge clkvideo) begin
    if (wr_en) mem[{wr_bank_sel, wr_slot}] <= rgb_in;
    rd_data <= mem[rd_addr];
  end

  // Output phase state register
  always_ff @(posedge clkvideo or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      out_h <= '0;
      pass  <= 1'b0;
    end else begin
      state <= state_n;
      out_h <= out_h_n;
      pass  <= pass_n;
    end
  end

  // Phase advance, replay wrap, restart and region decode for the next phase
  always_comb begin
    out_h_n = out_h;
    pass_n  = pass;
    lv_n    = hs_rise ? line_ok : line_valid;
    hw_n    = hs_rise ? hs_cnt  : hs_width;
    if (hs_rise) begin
      out_h_n = '0;
      pass_n  = 1'b0;
    end else if (state == S_IDLE) begin
      out_h_n = '0;
    end else if (out_h == line_len - LEN_ONE) begin
      out_h_n = '0;
      pass_n  = ~pass;
    end else begin
      out_h_n = out_h + LEN_ONE;
    end
    if (!lv_n)                state_n = S_IDLE;
    else if (out_h_n < hw_n)  state_n = S_SYNC;
    else                      state_n = S_ACTIVE;
    rd_addr = {~wr_bank, out_h[ADDR_W-1:0]};
    sync    = (state == S_SYNC);
    show    = (state == S_ACTIVE) && (out_h < LEN_MAX_SLOT);
  end

  // Two-stage output pipeline keeps sync/blank/vsync aligned with RAM data
  always_ff @(posedge clkvideo or negedge reset_n) begin
    if (!reset_n) begin
      show_d1   <= 1'b0;
      sync_d1   <= 1'b0;
      pass_d1   <= 1'b0;
      vs_d1     <= 1'b0;
      rgb_out   <= '0;
      hsync_out <= 1'b0;
      vsync_out <= 1'b0;
    end else begin
      show_d1   <= show;
      sync_d1   <= sync;
      pass_d1   <= pass;
      vs_d1     <= (out_h == '0) ? vsync_in : vs_d1;
      hsync_out <= sync_d1;
      vsync_out <= vs_d1;
      if (!show_d1)                    rgb_out <= '0;
      else if (pass_d1 && scanlines_en) rgb_out <= dim(rd_data);
      else                             rgb_out <= rd_data;
    end
  end

endmodule

// File: tb/tb_rgb_scandoubler.sv
// tb/tb_rgb_scandoubler.sv - randomized self-checking bench for rgb_scandoubler
module tb_rgb_scandoubler;

  logic        clkvideo = 1'b0;
  logic        reset_n = 1'b0;
  logic        ce_in = 1'b0;
  logic        hsync_in = 1'b0;
  logic        vsync_in = 1'b0;
  logic [11:0] rgb_in = '0;
  logic        scanlines_en = 1'b0;
  logic [11:0] rgb_out;
  logic        hsync_out;
  logic        vsync_out;
  logic        overflow;

  rgb_scandoubler dut (
    .clkvideo(clkvideo), .reset_n(reset_n), .ce_in(ce_in), .hsync_in(hsync_in),
    .vsync_in(vsync_in), .rgb_in(rgb_in), .scanlines_en(scanlines_en),
    .rgb_out(rgb_out), .hsync_out(hsync_out), .vsync_out(vsync_out), .overflow(overflow)
  );

  always #5 clkvideo = ~clkvideo;

  localparam int HIST = 16384;

  int n_assert = 0;
  int n_fail = 0;
  int cyc = 2;

  // Expected picture per output phase cycle, plus vsync hold history
  logic [11:0] e_rgb  [0:HIST-1];
  bit          e_pass [0:HIST-1];
  bit          e_hs   [0:HIST-1];
  bit          vs_hist[0:HIST-1];
  int          oh_hist[0:HIST-1];

  // Capture model: pixels of the line being received, by slot
  bit          prev_hs, seen, ovf, vs_hold;
  int          cnt, hcnt;
  logic [11:0] cap[$];
  // Display model: the line currently being replayed
  logic [11:0] dpix[$];
  int          dlen, dw, dt0;
  bit          dvalid;

  function automatic logic [11:0] halve(input logic [11:0] c);
    return (c >> 1) & 12'h777;
  endfunction

  task automatic model_reset();
    prev_hs = 0; seen = 0; ovf = 0; vs_hold = 0;
    cnt = 0; hcnt = 0; cap = {}; dpix = {}; dlen = 0; dw = 0; dt0 = 0; dvalid = 0;
    e_rgb[cyc] = 0; e_rgb[cyc-1] = 0; e_pass[cyc] = 0; e_pass[cyc-1] = 0;
    e_hs[cyc] = 0; e_hs[cyc-1] = 0; vs_hist[cyc] = 0; oh_hist[cyc] = 0;
  endtask

  task automatic model_edge(input bit ce, input bit hs, input bit vs, input logic [11:0] rgb);
    int oh;
    bit ps;
    if (ce) begin
      if (hs && !prev_hs) begin
        dvalid = seen && (cnt >= 2);
        dlen = cnt; dw = hcnt; dpix = cap; dt0 = cyc;
        seen = 1; cap = {rgb}; cnt = 1; hcnt = 1;
      end else begin
        if (cnt < 512) cap.push_back(rgb);
        else ovf = 1;
        cnt = (cnt < 1023) ? cnt + 1 : 1023;
        if (hs) hcnt = (hcnt < 1023) ? hcnt + 1 : 1023;
      end
      prev_hs = hs;
    end
    oh = dvalid ? (cyc - dt0) % dlen : 0;
    ps = dvalid ? (((cyc - dt0) / dlen) % 2 == 1) : 0;
    e_pass[cyc] = ps;
    if (!dvalid) begin
      e_rgb[cyc] = 0; e_hs[cyc] = 0;
    end else if (oh < dw) begin
      e_rgb[cyc] = 0; e_hs[cyc] = 1;
    end else begin
      e_rgb[cyc] = (oh < dpix.size()) ? dpix[oh] : 12'h000;
      e_hs[cyc] = 0;
    end
    if (oh_hist[cyc-1] == 0) vs_hold = vs;
    vs_hist[cyc] = vs_hold;
    oh_hist[cyc] = oh;
  endtask

  task automatic check_outputs();
    logic [11:0] exp_rgb;
    exp_rgb = (e_pass[cyc-2] && scanlines_en) ? halve(e_rgb[cyc-2]) : e_rgb[cyc-2];
    n_assert++;
    assert (rgb_out === exp_rgb) else begin
      n_fail++; $error("FAIL rgb_out cyc=%0d got %h expected %h", cyc, rgb_out, exp_rgb);
    end
    n_assert++;
    assert (hsync_out === e_hs[cyc-2]) else begin
      n_fail++; $error("FAIL hsync_out cyc=%0d got %b expected %b", cyc, hsync_out, e_hs[cyc-2]);
    end
    n_assert++;
    assert (vsync_out === vs_hist[cyc-1]) else begin
      n_fail++; $error("FAIL vsync_out cyc=%0d got %b expected %b", cyc, vsync_out, vs_hist[cyc-1]);
    end
    n_assert++;
    assert (overflow === ovf) else begin
      n_fail++; $error("FAIL overflow cyc=%0d got %b expected %b", cyc, overflow, ovf);
    end
  endtask

  task automatic check_zero(input string tag);
    n_assert++;
    assert ({rgb_out, hsync_out, vsync_out, overflow} === 15'h0) else begin
      n_fail++;
      $error("FAIL %s got rgb=%h hs=%b vs=%b ovf=%b expected all 0", tag, rgb_out, hsync_out, vsync_out, overflow);
    end
  endtask

  // Called at a falling edge: drive, clock, update model, check at next falling edge
  task automatic tick(input bit ce, input bit hs, input bit vs, input logic [11:0] rgb);
    ce_in = ce; hsync_in = hs; vsync_in = vs; rgb_in = rgb;
    @(posedge clkvideo);
    cyc++;
    model_edge(ce, hs, vs, rgb);
    @(negedge clkvideo);
    check_outputs();
  endtask

  // mode 0: ramp from 0, 1: constant 0xFFF, 2: random
  task automatic send_line(input int nhs, input int npx, input int mode, input bit vs);
    logic [11:0] px;
    for (int i = 0; i < nhs + npx; i++) begin
      if (i < nhs)        px = 12'($urandom);
      else if (mode == 0) px = 12'(i - nhs);
      else if (mode == 1) px = 12'hFFF;
      else                px = 12'($urandom);
      tick(1'b1, i < nhs, vs, px);
      tick(1'b0, i < nhs, vs, px);
    end
  endtask

  task automatic apply_reset(input bit async_mid);
    if (async_mid) #2;
    reset_n = 1'b0;
    #1;
    check_zero("reset_assert");
    ce_in = 0; hsync_in = 0; vsync_in = 0; rgb_in = 0;
    repeat (3) begin
      @(negedge clkvideo);
      check_zero("reset_hold");
    end
    reset_n = 1'b1;
    model_reset();
  endtask

  initial begin
    for (int i = 0; i < HIST; i++) begin
      e_rgb[i] = 0; e_pass[i] = 0; e_hs[i] = 0; vs_hist[i] = 0; oh_hist[i] = 0;
    end
    @(negedge clkvideo);
    apply_reset(1'b0);

    // Ramp lines: 8 sync + 100 pixels, doubled at 108 clk per output line
    scanlines_en = 1'b0;
    for (int l = 0; l < 3; l++) send_line(8, 100, 0, 1'b0);

    // Full-white with scanlines: second replay dimmed
    scanlines_en = 1'b1;
    for (int l = 0; l < 3; l++) send_line(8, 100, 1, 1'b0);

    // Overlong line, then a long line so slots past 512 get replayed, then normal
    scanlines_en = 1'b0;
    send_line(8, 600, 2, 1'b0);
    send_line(8, 400, 2, 1'b0);
    send_line(8, 100, 2, 1'b0);

    // Source hsync stalls: last captured line replays repeatedly
    for (int i = 0; i < 700; i++) tick(i % 2 == 0, 1'b0, 1'b0, 12'($urandom));

    // Vsync spanning two input lines
    send_line(8, 100, 2, 1'b0);
    send_line(8, 100, 2, 1'b1);
    send_line(8, 100, 2, 1'b1);
    send_line(8, 100, 2, 1'b0);
    send_line(8, 100, 2, 1'b0);

    // Randomized geometry, pixels and scanline setting
    for (int l = 0; l < 8; l++) begin
      scanlines_en = 1'($urandom);
      send_line($urandom_range(1, 12), $urandom_range(1, 150), 2, 1'($urandom));
    end

    // Reset in the middle of an active replay, then recovery
    send_line(8, 100, 2, 1'b0);
    send_line(8, 30, 2, 1'b0);
    apply_reset(1'b1);
    for (int l = 0; l < 3; l++) send_line(6, 80, 2, 1'b0);
    send_line(6, 10, 2, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
